noc_packet_sink: RTL and testbench
==================================

NOC_PACKET_SINK -- requirements
Module: noc_packet_sink

Interface
REQ-001 SHALL take parameter X_ID, default 0, meaning the local node X coordinate (Noc_ID_X_Width bits).
REQ-002 SHALL take parameter Y_ID, default 0, meaning the local node Y coordinate (Noc_ID_Y_Width bits).
REQ-003 SHALL have port noc_clk  input  1  the single clock; all state on its rising edge.
REQ-004 SHALL have port noc_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid  input  Noc_VC_Channel  per-VC flit valid from the router ejection port.
REQ-006 SHALL have port in_flit  input  Noc_VC_Channel x Noc_Flit_Width  per-VC flit {hdr_flag, tail_flag, data[Noc_Data_Width-1:0]}.
REQ-007 SHALL have port in_ready  output  Noc_VC_Channel  per-VC ready; flit accepted when in_valid[v] and in_ready[v] are both high.
REQ-008 SHALL have port pkt_valid  output  1  packet record available.
REQ-009 SHALL have port pkt_ready  input  1  consumer accepts the record.
REQ-010 SHALL have ports pkt_src_x / pkt_src_y  output  Noc_ID_X_Width / Noc_ID_Y_Width  source ID from header.
REQ-011 SHALL have port pkt_vc  output  $clog2(Noc_VC_Channel)  VC the packet arrived on.
REQ-012 SHALL have port pkt_len  output  8  count of body (non-header) flits including tail, saturating at 255.
REQ-013 SHALL have port pkt_xor  output  Noc_Data_Width  XOR of data fields of all body flits including tail.
REQ-014 SHALL have port pkt_dest_err  output  1  header destination differs from {X_ID, Y_ID}.
REQ-015 SHALL have port err_count  output  16  saturating protocol-error counter.

Function
REQ-016 SHALL run one independent reassembly FSM per VC with states IDLE and BODY.
REQ-017 Header flit SHALL mean hdr_flag=1 and data[Noc_Data_Width-1:Noc_Point_H]==Noc_Head_H; tail flit SHALL mean tail_flag=1 and marker field [Axi_Len_Point-1:Noc_Point_E]==Noc_Tail_E.
REQ-018 IDLE + accepted header: latch source/destination from [Noc_Point_H-1:Noc_Source_Point], clear len/xor, go BODY.
REQ-019 IDLE + header with tail_flag=1: immediately produce record with len=0, xor=0, stay IDLE.
REQ-020 IDLE + accepted non-header flit: drop, err_count+1, stay IDLE.
REQ-021 BODY + non-tail, non-header flit: len+1 (saturating), xor^=data.
REQ-022 BODY + tail: update len/xor as REQ-021, set record-pending for that VC, go IDLE.
REQ-023 BODY + header: err_count+1, discard partial packet, restart per REQ-018.
REQ-024 in_ready[v] SHALL equal NOT record-pending[v], driven from flops only (no in_valid path).
REQ-025 A pending record SHALL appear on pkt_* at the cycle after tail acceptance at earliest (1-cycle latency).
REQ-026 Multiple pending records SHALL be arbitrated round-robin; pointer moves past the granted VC only on pkt_valid&&pkt_ready.
REQ-027 pkt_* SHALL remain stable while pkt_valid && !pkt_ready; grant never changes mid-hold.
REQ-028 Record-pending[v] SHALL clear on handshake; in_ready[v] rises next cycle.
REQ-029 Two errors in one cycle (different VCs) SHALL add 2 to err_count; err_count saturates at 16'hFFFF.

Reset
REQ-030 On noc_rst_n low: all FSMs IDLE, no records pending, in_ready all 1, pkt_valid 0, pkt_* 0, err_count 0, RR pointer 0.
REQ-031 Reset mid-packet SHALL discard partial and pending packets without error count.

Structure
REQ-032 Noc_Flit_Width, a packed packet-record struct and the FSM state enum SHALL live in Noc_parameters.
REQ-033 Round-robin selection SHALL be a sub-module noc_rr_arbiter (request vector, advance strobe, one-hot grant).

Verification
REQ-034 VC0 header from (1,2) to local (0,0), data 0xA5, tail 0x0F -> one record src=(1,2), vc=0, len=2, xor=0xAA, dest_err=0.
REQ-035 Header dest (3,3) at node (0,0) -> record with dest_err=1, err_count unchanged.
REQ-036 Data flit on idle VC1 -> dropped, err_count=1, no record.
REQ-037 Tails on VC0 and VC1 same cycle, pkt_ready held low 3 cycles -> VC0 record stable 3 cycles, then VC1, in_ready[0]/[1] low until each handshake.
REQ-038 Reset asserted mid-body on VC0 -> pkt_valid 0, in_ready all 1, err_count 0, next full packet reported normally.

Source files
------------

// File: rtl/noc_packet_sink_pkg.sv
// Shared NoC sink definitions: flit layout, packet record, reassembly state.
// Headers carry {src_x, src_y, dst_x, dst_y} below the head marker; tails carry a marker in the low byte.
package Noc_parameters;

  localparam int Noc_ID_X_Width   = 4;
  localparam int Noc_ID_Y_Width   = 4;
  localparam int Noc_VC_Channel   = 4;
  localparam int Noc_VC_Width     = $clog2(Noc_VC_Channel);
  localparam int Noc_Data_Width   = 32;
  localparam int Noc_Flit_Width   = Noc_Data_Width + 2;
  localparam int Noc_Point_H      = 24;
  localparam int Noc_Source_Point = 8;
  localparam int Axi_Len_Point    = 8;
  localparam int Noc_Point_E      = 4;

  localparam logic [Noc_Data_Width-Noc_Point_H-1:0] Noc_Head_H = 8'hA0;
  localparam logic [Axi_Len_Point-Noc_Point_E-1:0]  Noc_Tail_E = 4'h0;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BODY = 1'b1
  } sink_state_e;

  typedef struct packed {
    logic [Noc_ID_X_Width-1:0] src_x;
    logic [Noc_ID_Y_Width-1:0] src_y;
    logic [Noc_ID_X_Width-1:0] dst_x;
    logic [Noc_ID_Y_Width-1:0] dst_y;
  } hdr_id_t;

  typedef struct packed {
    logic [Noc_ID_X_Width-1:0] src_x;
    logic [Noc_ID_Y_Width-1:0] src_y;
    logic [Noc_VC_Width-1:0]   vc;
    logic [7:0]                len;
    logic [Noc_Data_Width-1:0] xsum;
    logic                      dest_err;
  } pkt_rec_t;

  function automatic logic [Noc_VC_Width-1:0] onehot_to_idx(input logic [Noc_VC_Channel-1:0] oh);
    logic [Noc_VC_Width-1:0] idx;
    idx = '0;
    for (int i = 0; i < Noc_VC_Channel; i++) begin
      idx = idx | (oh[i] ? Noc_VC_Width'(i) : {Noc_VC_Width{1'b0}});
    end
    return idx;
  endfunction

endpackage

// File: rtl/noc_packet_sink_rr_arbiter.sv
// Round-robin arbiter: one-hot grant starting at the pointer; the pointer steps past the
// granted requester only on the advance strobe. N must be a power of two.
module noc_rr_arbiter #(
  parameter int N = 4
) (
  input  logic         noc_clk,
  input  logic         noc_rst_n,
  input  logic [N-1:0] req,
  input  logic         adv,
  output logic [N-1:0] grant
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [IW-1:0] ptr_r;
  logic [IW-1:0] gidx_s;
  logic [IW-1:0] idx_s;
  logic          found_s;
  logic          hit_s;

  // first requester at or after the pointer, index wrapping modulo N
  always_comb begin
    grant   = '0;
    gidx_s  = ptr_r;
    idx_s   = ptr_r;
    found_s = 1'b0;
    hit_s   = 1'b0;
    for (int i = 0; i < N; i++) begin
      idx_s   = ptr_r + IW'(i);
      hit_s   = !found_s && req[idx_s];
      grant   = grant | (hit_s ? ({{(N-1){1'b0}}, 1'b1} << idx_s) : {N{1'b0}});
      gidx_s  = hit_s ? idx_s : gidx_s;
      found_s = found_s | hit_s;
    end
  end

  // pointer update
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      ptr_r <= '0;
    end else if (adv && found_s) begin
      ptr_r <= gidx_s + IW'(1);
    end
  end

endmodule

// File: rtl/noc_packet_sink.sv
// NoC ejection sink: per-VC packet reassembly into summary records, round-robin
// delivery of completed records and a saturating protocol-error counter.
module noc_packet_sink
  import Noc_parameters::*;
#(
  parameter logic [Noc_ID_X_Width-1:0] X_ID = '0,
  parameter logic [Noc_ID_Y_Width-1:0] Y_ID = '0
) (
  input  logic                                     noc_clk,
  input  logic                                     noc_rst_n,
  input  logic [Noc_VC_Channel-1:0]                in_valid,
  input  logic [Noc_VC_Channel*Noc_Flit_Width-1:0] in_flit,
  output logic [Noc_VC_Channel-1:0]                in_ready,
  output logic                                     pkt_valid,
  input  logic                                     pkt_ready,
  output logic [Noc_ID_X_Width-1:0]                pkt_src_x,
  output logic [Noc_ID_Y_Width-1:0]                pkt_src_y,
  output logic [Noc_VC_Width-1:0]                  pkt_vc,
  output logic [7:0]                               pkt_len,
  output logic [Noc_Data_Width-1:0]                pkt_xor,
  output logic                                     pkt_dest_err,
  output logic [15:0]                              err_count
);

  localparam int NV = Noc_VC_Channel;
  localparam int EW = Noc_VC_Width + 1;

  sink_state_e               state_r [NV];
  pkt_rec_t                  rec_r   [NV];
  logic [NV-1:0]             pend_r;
  logic                      out_valid_r;
  pkt_rec_t                  out_rec_r;
  logic [15:0]               err_count_r;

  logic [Noc_Data_Width-1:0] data_s [NV];
  hdr_id_t                   id_s   [NV];
  logic [NV-1:0]             hflag_s, tflag_s, hdr_s, tail_s, acc_s, err_s;
  logic [NV-1:0]             req_s, grant_s;
  logic [Noc_VC_Width-1:0]   gidx_s;
  logic                      hs_s, load_s;
  logic [EW-1:0]             err_inc_s;
  logic [16:0]               err_sum_s;

  // flit decode and per-VC acceptance / protocol-error detection
  always_comb begin
    hflag_s = '0;
    tflag_s = '0;
    hdr_s   = '0;
    tail_s  = '0;
    acc_s   = '0;
    err_s   = '0;
    for (int v = 0; v < NV; v++) begin
      data_s[v]  = in_flit[v*Noc_Flit_Width +: Noc_Data_Width];
      hflag_s[v] = in_flit[v*Noc_Flit_Width + Noc_Flit_Width - 1];
      tflag_s[v] = in_flit[v*Noc_Flit_Width + Noc_Flit_Width - 2];
      id_s[v]    = hdr_id_t'(data_s[v][Noc_Point_H-1:Noc_Source_Point]);
      hdr_s[v]   = hflag_s[v] && (data_s[v][Noc_Data_Width-1:Noc_Point_H] == Noc_Head_H);
      tail_s[v]  = tflag_s[v] && (data_s[v][Axi_Len_Point-1:Noc_Point_E] == Noc_Tail_E);
      acc_s[v]   = in_valid[v] && !pend_r[v];
      // error: non-header while idle, or header interrupting a body
      err_s[v]   = acc_s[v] && ((state_r[v] == ST_IDLE) ^ hdr_s[v]);
    end
  end

  // error increment and arbitration controls
  always_comb begin
    err_inc_s = '0;
    for (int v = 0; v < NV; v++) begin
      err_inc_s = err_inc_s + EW'(err_s[v]);
    end
    err_sum_s = {1'b0, err_count_r} + 17'(err_inc_s);
    hs_s      = out_valid_r && pkt_ready;
    load_s    = !out_valid_r && (pend_r != '0);
    // while a record is held, only its VC requests so the grant cannot move
    if (out_valid_r) begin
      req_s = {{(NV-1){1'b0}}, 1'b1} << out_rec_r.vc;
    end else begin
      req_s = pend_r;
    end
    gidx_s = onehot_to_idx(grant_s);
  end

  noc_rr_arbiter #(
    .N (NV)
  ) u_rr_arbiter (
    .noc_clk   (noc_clk),
    .noc_rst_n (noc_rst_n),
    .req       (req_s),
    .adv       (hs_s),
    .grant     (grant_s)
  );

  // per-VC reassembly FSMs and record-pending flags
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      pend_r <= '0;
      for (int v = 0; v < NV; v++) begin
        state_r[v] <= ST_IDLE;
        rec_r[v]   <= '0;
      end
    end else begin
      for (int v = 0; v < NV; v++) begin
        if (acc_s[v] && hdr_s[v]) begin
          rec_r[v].src_x    <= id_s[v].src_x;
          rec_r[v].src_y    <= id_s[v].src_y;
          rec_r[v].vc       <= Noc_VC_Width'(v);
          rec_r[v].len      <= 8'd0;
          rec_r[v].xsum     <= '0;
          rec_r[v].dest_err <= (id_s[v].dst_x != X_ID) || (id_s[v].dst_y != Y_ID);
          pend_r[v]         <= tflag_s[v];
          state_r[v]        <= tflag_s[v] ? ST_IDLE : ST_BODY;
        end else if (acc_s[v] && (state_r[v] == ST_BODY)) begin
          rec_r[v].len  <= (rec_r[v].len == 8'hFF) ? 8'hFF : rec_r[v].len + 8'd1;
          rec_r[v].xsum <= rec_r[v].xsum ^ data_s[v];
          if (tail_s[v]) begin
            pend_r[v]  <= 1'b1;
            state_r[v] <= ST_IDLE;
          end
        end else if (hs_s && (out_rec_r.vc == Noc_VC_Width'(v))) begin
          pend_r[v] <= 1'b0;
        end
      end
    end
  end

  // output record register and error counter
  always_ff @(posedge noc_clk or negedge noc_rst_n) begin
    if (!noc_rst_n) begin
      out_valid_r <= 1'b0;
      out_rec_r   <= '0;
      err_count_r <= 16'h0000;
    end else begin
      if (hs_s) begin
        out_valid_r <= 1'b0;
      end else if (load_s) begin
        out_valid_r <= 1'b1;
        out_rec_r   <= rec_r[gidx_s];
      end
      err_count_r <= err_sum_s[16] ? 16'hFFFF : err_sum_s[15:0];
    end
  end

  assign in_ready     = ~pend_r;
  assign pkt_valid    = out_valid_r;
  assign pkt_src_x    = out_rec_r.src_x;
  assign pkt_src_y    = out_rec_r.src_y;
  assign pkt_vc       = out_rec_r.vc;
  assign pkt_len      = out_rec_r.len;
  assign pkt_xor      = out_rec_r.xsum;
  assign pkt_dest_err = out_rec_r.dest_err;
  assign err_count    = err_count_r;

endmodule

// File: tb/tb_noc_packet_sink.sv
// Randomized bench for noc_packet_sink against a packet-level reference model.
module tb_noc_packet_sink;
  import Noc_parameters::*;

  localparam int NV = Noc_VC_Channel;
  localparam int FW = Noc_Flit_Width;

  logic                      noc_clk   = 1'b0;
  logic                      noc_rst_n = 1'b0;
  logic [NV-1:0]             in_valid  = '0;
  logic [FW-1:0]             flit_v [NV];
  logic [NV*FW-1:0]          in_flit;
  logic [NV-1:0]             in_ready;
  logic                      pkt_valid;
  logic                      pkt_ready = 1'b0;
  logic [Noc_ID_X_Width-1:0] pkt_src_x;
  logic [Noc_ID_Y_Width-1:0] pkt_src_y;
  logic [Noc_VC_Width-1:0]   pkt_vc;
  logic [7:0]                pkt_len;
  logic [Noc_Data_Width-1:0] pkt_xor;
  logic                      pkt_dest_err;
  logic [15:0]               err_count;

  int n_vec = 0;
  int n_bad = 0;

  // reference model: packet-level view of each VC plus the delivery queue head
  bit         m_body [NV];
  bit         m_pend [NV];
  int         m_len  [NV];
  logic [31:0] m_xor [NV];
  logic [3:0] m_sx   [NV];
  logic [3:0] m_sy   [NV];
  bit         m_derr [NV];
  bit         m_valid;
  int         m_vc, m_ptr, m_err;

  noc_packet_sink dut (
    .noc_clk      (noc_clk),
    .noc_rst_n    (noc_rst_n),
    .in_valid     (in_valid),
    .in_flit      (in_flit),
    .in_ready     (in_ready),
    .pkt_valid    (pkt_valid),
    .pkt_ready    (pkt_ready),
    .pkt_src_x    (pkt_src_x),
    .pkt_src_y    (pkt_src_y),
    .pkt_vc       (pkt_vc),
    .pkt_len      (pkt_len),
    .pkt_xor      (pkt_xor),
    .pkt_dest_err (pkt_dest_err),
    .err_count    (err_count)
  );

  always #5 noc_clk = ~noc_clk;

  always_comb begin
    in_flit = '0;
    for (int v = 0; v < NV; v++) in_flit[v*FW +: FW] = flit_v[v];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [FW-1:0] mk_hdr(input logic [3:0] sx, input logic [3:0] sy,
                                           input logic [3:0] dx, input logic [3:0] dy, input logic tl);
    logic [7:0] lo;
    lo = 8'($urandom);
    return {1'b1, tl, 8'hA0, sx, sy, dx, dy, lo};
  endfunction

  function automatic logic [FW-1:0] mk_body(input logic [31:0] d);
    return {2'b00, d};
  endfunction

  function automatic logic [FW-1:0] mk_tail(input logic [31:0] d);
    logic [31:0] t;
    t = d;
    t[7:4] = 4'h0;
    return {2'b01, t};
  endfunction

  function automatic logic [63:0] rec_obs();
    return 64'({pkt_src_x, pkt_src_y, pkt_vc, pkt_len, pkt_xor, pkt_dest_err});
  endfunction

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_body[v] = 1'b0; m_pend[v] = 1'b0; m_len[v] = 0; m_xor[v] = '0;
      m_sx[v] = '0; m_sy[v] = '0; m_derr[v] = 1'b0;
    end
    m_valid = 1'b0; m_vc = 0; m_ptr = 0; m_err = 0;
  endtask

  // apply one clock edge of the packet rules to the model
  task automatic model_edge();
    bit hs, load, hdr, tl;
    int pick, errs;
    logic [FW-1:0] f;
    hs   = m_valid && pkt_ready;
    load = !m_valid;
    pick = -1;
    for (int i = 0; i < NV; i++) begin
      if (pick < 0 && m_pend[(m_ptr + i) % NV]) pick = (m_ptr + i) % NV;
    end
    load = load && (pick >= 0);
    errs = 0;
    for (int v = 0; v < NV; v++) begin
      if (in_valid[v] && !m_pend[v]) begin
        f   = flit_v[v];
        hdr = f[FW-1] && (f[31:24] == 8'hA0);
        tl  = f[FW-2] && (f[7:4] == 4'h0);
        if (hdr) begin
          if (m_body[v]) errs++;
          m_sx[v] = f[23:20]; m_sy[v] = f[19:16];
          m_derr[v] = (f[15:12] != 4'd0) || (f[11:8] != 4'd0);
          m_len[v] = 0; m_xor[v] = '0;
          m_pend[v] = f[FW-2];
          m_body[v] = !f[FW-2];
        end else if (m_body[v]) begin
          m_len[v] = (m_len[v] < 255) ? m_len[v] + 1 : 255;
          m_xor[v] = m_xor[v] ^ f[31:0];
          if (tl) begin m_pend[v] = 1'b1; m_body[v] = 1'b0; end
        end else begin
          errs++;
        end
      end
    end
    m_err = (m_err + errs > 65535) ? 65535 : m_err + errs;
    if (hs) begin m_pend[m_vc] = 1'b0; m_valid = 1'b0; m_ptr = (m_vc + 1) % NV; end
    if (load) begin m_valid = 1'b1; m_vc = pick; end
  endtask

  task automatic check_all();
    logic [NV-1:0] exp_rdy;
    for (int v = 0; v < NV; v++) exp_rdy[v] = !m_pend[v];
    check_val("in_ready", 64'(in_ready), 64'(exp_rdy));
    check_val("pkt_valid", 64'(pkt_valid), 64'(m_valid));
    check_val("err_count", 64'(err_count), 64'(m_err));
    if (m_valid) begin
      check_val("pkt_rec", rec_obs(), 64'({m_sx[m_vc], m_sy[m_vc], Noc_VC_Width'(m_vc),
                                           8'(m_len[m_vc]), m_xor[m_vc], m_derr[m_vc]}));
    end
  endtask

  task automatic cycle();
    @(posedge noc_clk);
    model_edge();
    @(negedge noc_clk);
    check_all();
  endtask

  task automatic drive(input int v, input logic [FW-1:0] f);
    in_valid[v] = 1'b1;
    flit_v[v]   = f;
  endtask

  task automatic idle();
    in_valid = '0;
  endtask

  task automatic do_reset();
    @(negedge noc_clk);
    noc_rst_n = 1'b0;
    in_valid  = '0;
    pkt_ready = 1'b0;
    model_reset();
    #1;
    check_val("rst_valid", 64'(pkt_valid), 64'(1'b0));
    check_val("rst_ready", 64'(in_ready), 64'({NV{1'b1}}));
    check_val("rst_err", 64'(err_count), 64'(16'h0000));
    check_val("rst_rec", rec_obs(), 64'(0));
    repeat (2) @(negedge noc_clk);
    noc_rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string tag, input int budget);
    int n;
    n = 0;
    while (!pkt_valid && n < budget) begin
      cycle();
      n++;
    end
    check_val({tag, "_timeout"}, 64'(pkt_valid), 64'(1'b1));
  endtask

  task automatic handshake();
    pkt_ready = 1'b1;
    cycle();
    pkt_ready = 1'b0;
  endtask

  initial begin
    for (int v = 0; v < NV; v++) flit_v[v] = '0;
    model_reset();
    do_reset();

    // basic packet: header (1,2)->(0,0), body 0xA5, tail 0x0F
    drive(0, mk_hdr(4'd1, 4'd2, 4'd0, 4'd0, 1'b0)); cycle();
    drive(0, mk_body(32'h0000_00A5)); cycle();
    drive(0, mk_tail(32'h0000_000F)); cycle();
    idle();
    wait_valid("t_basic", 4);
    check_val("t_basic_rec", rec_obs(), 64'({4'd1, 4'd2, 2'd0, 8'd2, 32'h0000_00AA, 1'b0}));
    handshake();

    // wrong destination flags the record but is not a protocol error
    drive(0, mk_hdr(4'd5, 4'd6, 4'd3, 4'd3, 1'b0)); cycle();
    drive(0, mk_tail(32'h0000_0001)); cycle();
    idle();
    wait_valid("t_dest", 4);
    check_val("t_dest_err", 64'(pkt_dest_err), 64'(1'b1));
    check_val("t_dest_cnt", 64'(err_count), 64'(16'd0));
    handshake();

    // stray data on idle VC1
    drive(1, mk_body(32'h0000_1234)); cycle();
    idle();
    repeat (3) cycle();
    check_val("t_drop_cnt", 64'(err_count), 64'(16'd1));
    check_val("t_drop_valid", 64'(pkt_valid), 64'(1'b0));

    // simultaneous tails on VC0/VC1 with consumer stalling
    do_reset();
    drive(0, mk_hdr(4'd1, 4'd1, 4'd0, 4'd0, 1'b0));
    drive(1, mk_hdr(4'd2, 4'd2, 4'd0, 4'd0, 1'b0)); cycle();
    drive(0, mk_tail(32'h0000_0003));
    drive(1, mk_tail(32'h0000_0009)); cycle();
    idle();
    wait_valid("t_rr0", 4);
    for (int k = 0; k < 3; k++) begin
      check_val("t_rr_hold_vc", 64'(pkt_vc), 64'(0));
      check_val("t_rr_hold_rdy", 64'(in_ready[1:0]), 64'(2'b00));
      if (k < 2) cycle();
    end
    handshake();
    check_val("t_rr_rdy0", 64'(in_ready[1:0]), 64'(2'b01));
    wait_valid("t_rr1", 4);
    check_val("t_rr_vc1", 64'(pkt_vc), 64'(1));
    handshake();
    check_val("t_rr_rdy1", 64'(in_ready[1:0]), 64'(2'b11));

    // reset in the middle of a body, after an error was counted
    drive(1, mk_body(32'h0000_0077)); cycle();
    idle();
    drive(0, mk_hdr(4'd9, 4'd9, 4'd0, 4'd0, 1'b0)); cycle();
    drive(0, mk_body(32'h0000_5555)); cycle();
    do_reset();
    drive(0, mk_hdr(4'd3, 4'd4, 4'd0, 4'd0, 1'b0)); cycle();
    drive(0, mk_body(32'h0000_0011)); cycle();
    drive(0, mk_body(32'h0000_0022)); cycle();
    drive(0, mk_tail(32'h0000_0005)); cycle();
    idle();
    wait_valid("t_rst", 4);
    check_val("t_rst_rec", rec_obs(), 64'({4'd3, 4'd4, 2'd0, 8'd3, 32'h0000_0036, 1'b0}));
    handshake();

    // body length saturates at 255
    drive(2, mk_hdr(4'd7, 4'd7, 4'd0, 4'd0, 1'b0)); cycle();
    for (int i = 0; i < 300; i++) begin
      drive(2, mk_body(32'(i))); cycle();
    end
    drive(2, mk_tail(32'h0000_0000)); cycle();
    idle();
    wait_valid("t_sat", 4);
    check_val("t_sat_len", 64'(pkt_len), 64'(8'hFF));
    check_val("t_sat_vc", 64'(pkt_vc), 64'(2));
    handshake();

    // randomized traffic on all VCs
    for (int c = 0; c < 3000; c++) begin
      for (int v = 0; v < NV; v++) begin
        int r;
        r = $urandom_range(0, 99);
        in_valid[v] = ($urandom_range(0, 9) < 7);
        if (r < 10) begin
          flit_v[v] = mk_hdr(4'($urandom), 4'($urandom),
                             ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'd0,
                             ($urandom_range(0, 4) == 0) ? 4'($urandom) : 4'd0,
                             ($urandom_range(0, 6) == 0));
        end else if (r < 20) begin
          flit_v[v] = {2'($urandom), 32'($urandom)};
        end else if (r < 35) begin
          flit_v[v] = mk_tail(32'($urandom));
        end else begin
          flit_v[v] = mk_body(32'($urandom));
        end
      end
      pkt_ready = ($urandom_range(0, 9) < 6);
      cycle();
    end
    idle();
    pkt_ready = 1'b0;

    // four stray flits per cycle drive the error counter into saturation
    do_reset();
    for (int c = 0; c < 16400; c++) begin
      for (int v = 0; v < NV; v++) drive(v, mk_body(32'($urandom)));
      cycle();
    end
    idle();
    check_val("t_err_sat", 64'(err_count), 64'(16'hFFFF));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
